// File: rtl/m16_deframer.sv
// m16_deframer: receive side of the M16 telemetry framer.
// Oversamples the serial NRZ line, recovers bits, hunts for the group/frame
// marker, verifies it over LOCK_COUNT groups, then streams every 12-bit word
// with its in-group address and group number as a write-strobe stream.
//
// Ports:
//   clk          sampling clock (clk100)
//   reset        synchronous, active-high
//   iSerial      asynchronous NRZ serial input, MSB first
//   oWord        assembled 12-bit word
//   oAddr        word index within group (0 = marker word)
//   oNumGrp      group index within frame (0 until a frame marker is seen)
//   oWrEn        one-cycle strobe qualifying oWord/oAddr/oNumGrp
//   oLocked      high while locked
//   oFrameStart  one-cycle pulse with oWrEn on word 0 of group 0
//   oSyncErr     one-cycle pulse on each bad marker while verifying/locked
module m16_deframer #(
    parameter int          CLKS_PER_BIT   = 32,
    parameter int          WORDS_PER_GRP  = 2048,
    parameter int          GRPS_PER_FRAME = 32,
    parameter logic [11:0] SYNC_WORD      = 12'h72E,
    parameter int          LOCK_COUNT     = 2,
    parameter int          LOSS_COUNT     = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iSerial,
    output logic [11:0] oWord,
    output logic [10:0] oAddr,
    output logic [4:0]  oNumGrp,
    output logic        oWrEn,
    output logic        oLocked,
    output logic        oFrameStart,
    output logic        oSyncErr
);

    localparam int          PW         = $clog2(CLKS_PER_BIT);
    localparam logic [PW-1:0] PH_LAST  = PW'(CLKS_PER_BIT - 1);
    localparam logic [PW-1:0] PH_EDGE  = PW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [10:0] W_LAST     = 11'(WORDS_PER_GRP - 1);
    localparam logic [4:0]  G_LAST     = 5'(GRPS_PER_FRAME - 1);
    localparam logic [11:0] FRAME_WORD = ~SYNC_WORD;
    localparam logic [7:0]  LOCK_N     = 8'(LOCK_COUNT);
    localparam logic [7:0]  LOSS_N     = 8'(LOSS_COUNT);

    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;
    state_t state, stateNext;

    logic          sync1, sync2, sync3;
    logic          edgeDet, bitTick, wordDone, atMarker;
    logic [PW-1:0] phase;
    logic [11:0]   sr, srNext;
    logic          isGrp, isFrame, isMarker;
    logic [3:0]    bitCnt;
    logic [10:0]   wcnt, wcntInc;
    logic [4:0]    gcnt, gcntNext, gcntInc, grpOut;
    logic          gvalid, gvalidNext;
    logic [7:0]    good, goodNext, goodPlus;
    logic [7:0]    miss, missNext, missPlus;
    logic          hit, emit, err, fs;

    assign edgeDet  = sync2 ^ sync3;
    // Edge reload puts the next sample CLKS_PER_BIT/2 cycles later, mid-bit.
    assign bitTick  = (phase == PH_LAST);
    // Word/marker decisions use the word as it will look after this shift.
    assign srNext   = {sr[10:0], sync2};
    assign isGrp    = (srNext == SYNC_WORD);
    assign isFrame  = (srNext == FRAME_WORD);
    assign isMarker = isGrp | isFrame;
    assign wordDone = bitTick && (bitCnt == 4'd11);
    assign atMarker = (wcnt == 11'd0);
    assign wcntInc  = (wcnt == W_LAST) ? 11'd0 : wcnt + 11'd1;
    assign gcntInc  = (gcnt == G_LAST) ? 5'd0 : gcnt + 5'd1;
    assign goodPlus = good + 8'd1;
    assign missPlus = miss + 8'd1;
    assign oLocked  = (state == LOCKED);

    always_ff @(posedge clk) begin
        if (reset) state <= HUNT;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext  = state;
        hit        = 1'b0;
        emit       = 1'b0;
        err        = 1'b0;
        goodNext   = good;
        missNext   = miss;
        gcntNext   = gcnt;
        gvalidNext = gvalid;
        case (state)
            HUNT: begin
                if (bitTick && isMarker) begin
                    hit        = 1'b1;
                    stateNext  = VERIFY;
                    goodNext   = 8'd1;
                    missNext   = 8'd0;
                    gvalidNext = isFrame;
                    if (isFrame) gcntNext = 5'd0;
                end
            end
            VERIFY: begin
                if (wordDone && atMarker) begin
                    if (isMarker) begin
                        goodNext = goodPlus;
                        gcntNext = isFrame ? 5'd0 : gcntInc;
                        if (isFrame) gvalidNext = 1'b1;
                        // The marker that completes verification is the first word out.
                        if (goodPlus >= LOCK_N) begin
                            stateNext = LOCKED;
                            missNext  = 8'd0;
                            emit      = 1'b1;
                        end
                    end else begin
                        err        = 1'b1;
                        stateNext  = HUNT;
                        gvalidNext = 1'b0;
                    end
                end
            end
            LOCKED: begin
                if (wordDone) begin
                    emit = 1'b1;
                    if (atMarker) begin
                        if (isMarker) begin
                            missNext = 8'd0;
                            gcntNext = isFrame ? 5'd0 : gcntInc;
                            if (isFrame) gvalidNext = 1'b1;
                        end else begin
                            // Coast through a bad marker; the loss-causing one is not output.
                            err      = 1'b1;
                            missNext = missPlus;
                            gcntNext = gcntInc;
                            if (missPlus >= LOSS_N) begin
                                emit       = 1'b0;
                                stateNext  = HUNT;
                                gvalidNext = 1'b0;
                            end
                        end
                    end
                end
            end
            default: stateNext = HUNT;
        endcase
    end

    assign grpOut = gvalidNext ? gcntNext : 5'd0;
    assign fs     = emit && atMarker && gvalidNext && (gcntNext == 5'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1       <= 1'b0;
            sync2       <= 1'b0;
            sync3       <= 1'b0;
            phase       <= '0;
            sr          <= 12'd0;
            bitCnt      <= 4'd0;
            wcnt        <= 11'd0;
            gcnt        <= 5'd0;
            gvalid      <= 1'b0;
            good        <= 8'd0;
            miss        <= 8'd0;
            oWord       <= 12'd0;
            oAddr       <= 11'd0;
            oNumGrp     <= 5'd0;
            oWrEn       <= 1'b0;
            oFrameStart <= 1'b0;
            oSyncErr    <= 1'b0;
        end else begin
            sync1 <= iSerial;
            sync2 <= sync1;
            sync3 <= sync2;
            if (edgeDet)      phase <= PH_EDGE;
            else if (bitTick) phase <= '0;
            else              phase <= phase + PW'(1);
            if (bitTick) begin
                sr <= srNext;
                if (hit) begin
                    // Marker just ended: next bit starts word 1.
                    bitCnt <= 4'd0;
                    wcnt   <= 11'd1;
                end else begin
                    bitCnt <= wordDone ? 4'd0 : bitCnt + 4'd1;
                    if (wordDone) wcnt <= wcntInc;
                end
            end
            gcnt        <= gcntNext;
            gvalid      <= gvalidNext;
            good        <= goodNext;
            miss        <= missNext;
            oWrEn       <= emit;
            oSyncErr    <= err;
            oFrameStart <= fs;
            if (emit) begin
                oWord   <= srNext;
                oAddr   <= wcnt;
                oNumGrp <= grpOut;
            end
        end
    end

endmodule
